// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF_ID-side and ID/EX-side handshake bundle of the decode stage
interface id_stage_pipe_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic [REG_AW-1:0] in_ad1;
    logic [DATA_W-1:0] in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_opcode;
    logic [REG_AW-1:0] out_dest;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_reg_val;
    logic [DATA_W-1:0] out_acc_val;
    logic              out_reg_write;
    logic              out_mem_write;
    logic              out_acc_write;

    modport master (
        output in_valid, in_opcode, in_ad1, in_imm, out_ready,
        input  in_ready, out_valid, out_opcode, out_dest, out_imm, out_reg_val,
               out_acc_val, out_reg_write, out_mem_write, out_acc_write
    );

    modport slave (
        input  in_valid, in_opcode, in_ad1, in_imm, out_ready,
        output in_ready, out_valid, out_opcode, out_dest, out_imm, out_reg_val,
               out_acc_val, out_reg_write, out_mem_write, out_acc_write
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered decode stage with operand forwarding, load-use stall and halt
module id_stage_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_pipe_if.slave    bus,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] acc_value,
    input  logic              flush,
    input  logic              ex_wr_en,
    input  logic [REG_AW-1:0] ex_wr_addr,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic              ex_acc_wr,
    input  logic [DATA_W-1:0] ex_acc_data,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);
    localparam logic [2:0] OP_LDO = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STO = 3'b011;
    localparam logic [2:0] OP_PRE = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_LDM = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] STALL  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]        state;
    logic              load_en;
    logic              hazard;
    logic              accept;
    logic              reg_w;
    logic              mem_w;
    logic              acc_w;
    logic              stall_now;
    logic [DATA_W-1:0] fwd_reg;
    logic [DATA_W-1:0] fwd_acc;

    always_comb begin
        load_en = !bus.out_valid || bus.out_ready;
        hazard  = bus.in_valid && bus.out_valid
                  && (bus.out_opcode == OP_LDO || bus.out_opcode == OP_LDA)
                  && (bus.in_opcode == OP_STO || bus.in_opcode == OP_PRE || bus.in_opcode == OP_ADD)
                  && bus.in_ad1 == bus.out_dest;
        bus.in_ready = rst && load_en && !hazard && state != HALTED && !flush;
        accept    = bus.in_valid && bus.in_ready;
        stall_now = state == RUN && hazard && load_en && !flush;
        reg_w = bus.in_opcode == OP_LDO || bus.in_opcode == OP_LDA || bus.in_opcode == OP_LDM;
        mem_w = bus.in_opcode == OP_STO;
        acc_w = bus.in_opcode == OP_PRE || bus.in_opcode == OP_ADD;
        // The younger EX result overrides WB when both target the operand register
        fwd_reg = (ex_wr_en && ex_wr_addr == bus.in_ad1) ? ex_wr_data :
                  (wb_wr_en && wb_wr_addr == bus.in_ad1) ? wb_wr_data : reg_data;
        fwd_acc = ex_acc_wr ? ex_acc_data : acc_value;
        halted  = state == HALTED;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= RUN;
            stall_count       <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_opcode    <= '0;
            bus.out_dest      <= '0;
            bus.out_imm       <= '0;
            bus.out_reg_val   <= '0;
            bus.out_acc_val   <= '0;
            bus.out_reg_write <= 1'b0;
            bus.out_mem_write <= 1'b0;
            bus.out_acc_write <= 1'b0;
        end else begin
            // Flush kills the ID/EX entry even under backpressure
            if (flush || load_en) begin
                bus.out_valid     <= accept;
                bus.out_reg_write <= accept && reg_w;
                bus.out_mem_write <= accept && mem_w;
                bus.out_acc_write <= accept && acc_w;
            end
            if (accept) begin
                bus.out_opcode  <= bus.in_opcode;
                bus.out_dest    <= bus.in_ad1;
                bus.out_imm     <= bus.in_imm;
                bus.out_reg_val <= fwd_reg;
                bus.out_acc_val <= fwd_acc;
            end
            if (state == HALTED)
                state <= HALTED;
            else if (accept && bus.in_opcode == OP_HLT)
                state <= HALTED;
            else if (stall_now)
                state <= STALL;
            else
                state <= RUN;
            if (stall_now && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised decode stage between the IF_ID register and EX_stage in cpu_pipeline.
- Decodes the 3-bit opcode into write controls and forwards register and accumulator operands from EX and WB.
- Detects load-use hazards and inserts bubbles; latches HLT into a halted state.
- Holds the ID/EX pipeline register internally, with a valid/ready handshake on both sides.

Parameters:
- DATA_W, 8, width of register, accumulator and immediate data
- REG_AW, 5, register address width (in_ad1 / dest)
- CNT_W, 8, width of the saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  IF_ID holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  3  opcode
- in_ad1  in  REG_AW  operand/destination register address
- in_imm  in  DATA_W  immediate
- reg_data  in  DATA_W  register file read data at in_ad1
- acc_value  in  DATA_W  architectural accumulator
- flush  in  1  kill the instruction in the ID/EX register and any pending stall
- ex_wr_en, ex_wr_addr, ex_wr_data  in  1/REG_AW/DATA_W  EX/MEM register-write forward
- wb_wr_en, wb_wr_addr, wb_wr_data  in  1/REG_AW/DATA_W  WB register-write forward
- ex_acc_wr, ex_acc_data  in  1/DATA_W  accumulator-write forward from EX
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX accepts
- out_opcode  out  3  registered opcode
- out_dest  out  REG_AW  registered in_ad1
- out_imm  out  DATA_W  registered immediate
- out_reg_val  out  DATA_W  forwarded register operand
- out_acc_val  out  DATA_W  forwarded accumulator operand
- out_reg_write  out  1  register-file write enable
- out_mem_write  out  1  data-memory write enable
- out_acc_write  out  1  accumulator write enable
- halted  out  1  HLT has been accepted
- stall_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst=0 at a clk edge):
  - All registered outputs go to 0 and state goes to RUN.
  - in_ready is 0 while rst=0.
- Opcode decode (same encoding as EX_stage):
  - NOP 000: no writes.
  - LDO 001 and LDA 010: reg_write.
  - STO 011: mem_write; reads register.
  - PRE 100: acc_write; reads register.
  - ADD 101: acc_write; reads register and accumulator.
  - LDM 110: reg_write; reads accumulator.
  - HLT 111: no writes.
- Load enable: load_en = !out_valid | out_ready.
- Load-use hazard: hazard = in_valid & out_valid & out_opcode∈{LDO,LDA} & in_opcode∈{STO,PRE,ADD} & in_ad1==out_dest.
- in_ready = rst & load_en & !hazard & state!=HALTED & !flush.
- Register operand forwarding priority, highest first:
  - ex_wr_en & ex_wr_addr==in_ad1 → ex_wr_data
  - otherwise wb_wr_en & wb_wr_addr==in_ad1 → wb_wr_data
  - otherwise reg_data
- Accumulator operand: ex_acc_wr ? ex_acc_data : acc_value.
- Register update on a clk edge with load_en=1:
  - If in_valid & in_ready: capture the decoded instruction and set out_valid=1.
  - Otherwise: out_valid=0 and all write enables 0 (bubble); the data fields may hold stale values.
- With load_en=0, the ID/EX register holds all fields unchanged.
- Latency: one cycle from acceptance to out_valid.
- FSM states:
  - RUN: normal operation. hazard & load_en & !flush → STALL. Accepted HLT → HALTED.
  - STALL: one bubble has been issued this cycle; stall_count increments, saturating at all-ones. Next cycle → RUN and the hazard is re-evaluated; the instruction is typically accepted then, with its data via the EX forward.
  - HALTED: the accepted HLT passes to EX. in_ready=0 and bubbles are issued forever. halted=1. Exit only by reset.
- Flush (highest priority after reset):
  - Next edge: out_valid=0 and all write enables 0.
  - STALL → RUN.
  - No acceptance occurs in the flush cycle.
  - HALTED is unaffected.
- Simultaneous hazard and out_ready=0: the stall is not counted until load_en=1.
- Write enables are never 1 while out_valid=0.

Test Plan:
- Reset then LDM: hold rst=0 for 2 cycles → all outputs 0. Release rst, in_valid=1, LDM ad1=3, acc_value=0x2A → next cycle out_valid=1, out_reg_write=1, out_acc_val=0x2A, out_dest=3.
- Load-use stall: LDA ad1=4 accepted, then ADD ad1=4 →
  - Cycle 1: in_ready=0, bubble, stall_count=1.
  - Cycle 2: ex_wr_en=1, ex_wr_addr=4, ex_wr_data=0x55 → ADD accepted with out_reg_val=0x55.
- Forward priority: ex (addr 2, 0x11) and wb (addr 2, 0x22) both asserted, STO ad1=2 → out_reg_val=0x11, out_mem_write=1. Drop ex_wr_en → 0x22. Drop both → reg_data.
- Backpressure: out_ready=0 for 3 cycles with PRE held in the register → outputs stable, in_ready=0. Raise out_ready → the next instruction loads the following cycle.
- Halt: HLT accepted → halted=1 next cycle. NOP/ADD presented for 5 cycles → in_ready=0, out_valid=0. flush → halted stays 1. rst=0 → halted=0.
- Flush mid-stall: hazard cycle with flush=1 → out_valid=0, state RUN, stall_count unchanged, no acceptance.
